// File: rtl/stroke_phase_detector.sv
// Flywheel sensor edge timing and rowing stroke phase classification.
// Emits start_drive / start_recovery pulses from a confirmed acceleration/deceleration streak.
module stroke_phase_detector #(
    parameter int unsigned PERIOD_W   = 32,
    parameter int unsigned MIN_PERIOD = 64,
    parameter int unsigned CONFIRM    = 2,
    parameter int unsigned TIMEOUT    = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sensor_in,
    output logic                start_drive,
    output logic                start_recovery,
    output logic [1:0]          phase,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic [15:0]         stroke_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DRIVE    = 2'b01,
        RECOVERY = 2'b10
    } phase_t;

    localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] TMO    = PERIOD_W'(TIMEOUT);
    localparam logic [3:0]          CONF   = 4'(CONFIRM);

    phase_t                state, state_n;
    logic                  sync1, sync2, sync3;
    logic                  rise, accept;
    logic [PERIOD_W-1:0]   cnt, cnt_n, period_n;
    logic                  armed, armed_n, have_prev, have_prev_n;
    logic [3:0]            acc, dec, acc_n, dec_n;
    logic                  sd_n, sr_n, pv_n;
    logic [15:0]           sc_n;

    assign rise   = sync2 & ~sync3;
    assign accept = rise && (!armed || cnt >= MIN_P);
    assign phase  = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1          <= 1'b0;
            sync2          <= 1'b0;
            sync3          <= 1'b0;
            state          <= IDLE;
            cnt            <= '0;
            armed          <= 1'b0;
            have_prev      <= 1'b0;
            acc            <= '0;
            dec            <= '0;
            period         <= '0;
            period_valid   <= 1'b0;
            start_drive    <= 1'b0;
            start_recovery <= 1'b0;
            stroke_count   <= '0;
        end else begin
            sync1          <= sensor_in;
            sync2          <= sync1;
            sync3          <= sync2;
            state          <= state_n;
            cnt            <= cnt_n;
            armed          <= armed_n;
            have_prev      <= have_prev_n;
            acc            <= acc_n;
            dec            <= dec_n;
            period         <= period_n;
            period_valid   <= pv_n;
            start_drive    <= sd_n;
            start_recovery <= sr_n;
            stroke_count   <= sc_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = (cnt == '1) ? cnt : cnt + 1'b1;
        armed_n     = armed;
        have_prev_n = have_prev;
        acc_n       = acc;
        dec_n       = dec;
        period_n    = period;
        pv_n        = 1'b0;
        sd_n        = 1'b0;
        sr_n        = 1'b0;
        sc_n        = stroke_count;

        if (accept) begin
            cnt_n = PERIOD_W'(1);
            if (!armed) begin
                armed_n = 1'b1;
            end else begin
                period_n    = cnt;
                pv_n        = 1'b1;
                have_prev_n = 1'b1;
                // The stored period doubles as the previous period; have_prev gates its use.
                if (have_prev) begin
                    if (cnt < period) begin
                        acc_n = (acc == 4'hF) ? acc : acc + 4'd1;
                        dec_n = '0;
                    end else if (cnt > period) begin
                        dec_n = (dec == 4'hF) ? dec : dec + 4'd1;
                        acc_n = '0;
                    end else begin
                        acc_n = '0;
                        dec_n = '0;
                    end
                    case (state)
                        IDLE, RECOVERY: begin
                            if (acc_n >= CONF) begin
                                state_n = DRIVE;
                                sd_n    = 1'b1;
                                sc_n    = stroke_count + 16'd1;
                                acc_n   = '0;
                                dec_n   = '0;
                            end
                        end
                        DRIVE: begin
                            if (dec_n >= CONF) begin
                                state_n = RECOVERY;
                                sr_n    = 1'b1;
                                acc_n   = '0;
                                dec_n   = '0;
                            end
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
        end else if (armed && cnt >= TMO) begin
            state_n     = IDLE;
            armed_n     = 1'b0;
            have_prev_n = 1'b0;
            acc_n       = '0;
            dec_n       = '0;
        end
    end

endmodule

// File: doc/stroke_phase_detector.md
# stroke_phase_detector

Converts the raw flywheel sensor pulse train into rowing stroke phase events. Measures the clock-cycle period between debounced sensor edges, classifies the flywheel as accelerating (drive) or decelerating (recovery) with a confirmation streak, and emits one-cycle `start_drive` / `start_recovery` pulses. Sits directly upstream of the ratio stage, which consumes those pulses, and shares its clock.

## Interface
- `PERIOD_W`, 32: width of the period counter and the `period` output.
- `MIN_PERIOD`, 64: minimum cycles between accepted edges; closer edges are treated as bounce and ignored.
- `CONFIRM`, 2: consecutive same-direction period comparisons required to change phase; legal range 1..15.
- `TIMEOUT`, 50_000_000: cycles without an accepted edge before the block returns to idle; must be less than 2^PERIOD_W − 1.

- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `sensor_in`  in  1  raw flywheel sensor; asynchronous, may bounce.
- `start_drive`  out  1  one-cycle pulse on entry to DRIVE.
- `start_recovery`  out  1  one-cycle pulse on entry to RECOVERY.
- `phase`  out  2  00 IDLE, 01 DRIVE, 10 RECOVERY; 11 never driven.
- `period`  out  PERIOD_W  last captured edge-to-edge period in cycles.
- `period_valid`  out  1  one-cycle pulse when `period` updates.
- `stroke_count`  out  16  number of `start_drive` pulses; wraps 0xFFFF→0.

## Operation
- `sensor_in` passes through a 2-FF synchronizer plus one history FF. Rise = sync2 & ~sync3.
- `cnt` increments every cycle and saturates at all ones.
- An edge is accepted when rise is high and either the block is unarmed or `cnt` ≥ MIN_PERIOD. On acceptance, `cnt` ← 1.
- First accepted edge after IDLE only arms the block; `period` is not updated.
- Each later accepted edge does `period` ← `cnt` and pulses `period_valid`. If a previous period exists, compare:
  - cur < prev: `acc` increments (saturating) and `dec` ← 0.
  - cur > prev: `dec` increments and `acc` ← 0.
  - equal: both streaks ← 0.
- FSM transitions (evaluated with the updated streak values):
  - IDLE → DRIVE when `acc` reaches CONFIRM. Decelerations in IDLE only update the streaks.
  - RECOVERY → DRIVE when `acc` reaches CONFIRM. Pulse `start_drive` and increment `stroke_count`.
  - DRIVE → RECOVERY when `dec` reaches CONFIRM. Pulse `start_recovery`.
  - Streaks clear on every phase change.
- Timeout: in any armed state, when `cnt` reaches TIMEOUT go to IDLE. This disarms the block, clears both streaks, and discards the previous period. No pulse is emitted. `period` and `stroke_count` hold their values.
- If timeout and an accepted edge occur in the same cycle, the edge wins.
- Reset (reset = 0 at a clock edge), including mid-stroke:
  - `phase` = 00; `start_drive`, `start_recovery`, `period_valid` = 0.
  - `period` = 0; `stroke_count` = 0; `cnt` = 0.
  - Unarmed, streaks = 0, synchronizer FFs = 0.

## Timing
- All outputs are registered.
- Latency: if `sensor_in` is first sampled high at edge k, then `period`, `period_valid`, `phase` and the start pulses update at edge k+2.
- A rising edge is missed only if `sensor_in` is high for less than one clock period.
- Pulses are exactly one cycle. `start_drive` and `start_recovery` are never high in the same cycle.
- The `phase` change and its start pulse appear in the same cycle.
- `stroke_count` updates in the same cycle as `start_drive`.
- For edges at times t0 < t1, the captured period equals t1 − t0 in clock cycles.

## Test plan
- Reset: hold reset = 0 for 3 cycles with `sensor_in` toggling -> all outputs 0 and `phase` = 00. Release -> outputs unchanged until the second accepted edge.
- Acceleration (CONFIRM=2): edges at 0, 1000, 1900, 2700 -> `period` = 1000, 900, 800 with 3 `period_valid` pulses. `start_drive` fires 2 cycles after the 4th edge; `phase` = 01; `stroke_count` = 1.
- Full stroke: continue from the previous scenario with periods 850, 900, then 700, 600 -> `start_recovery` after the 900 edge, then `start_drive` after the 600 edge; `stroke_count` = 2. Equal periods 800, 800 in DRIVE -> no pulse.
- Bounce: MIN_PERIOD=64, edges at 0, 20, 1000 -> the edge at 20 is ignored and `period` = 1000.
- Timeout: TIMEOUT=5000 in DRIVE, no edges -> `phase` = 00 at `cnt` = 5000 with no pulse; `period` and `stroke_count` held. The next edge only re-arms and produces no `period_valid`.
- Mid-operation reset in RECOVERY -> next cycle everything is 0/IDLE. The post-reset sequence 0, 1000, 900, 800 reproduces the acceleration scenario exactly.
